// File: rtl/ast_pkt_arb_pkg.sv
// Shared types and helpers for the Avalon-ST packet arbiter.
package ast_pkt_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int unsigned BEAT_DATA_W    = 64;
  localparam int unsigned BEAT_EMPTY_W   = 3;
  localparam int unsigned BEAT_CHANNEL_W = 8;

  // Width of a port index; never below one bit.
  function automatic int unsigned grant_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEFAULT_GRANT_W = grant_w(4);

  typedef struct packed {
    logic [BEAT_DATA_W-1:0]    data;
    logic                      sop;
    logic                      eop;
    logic [BEAT_EMPTY_W-1:0]   empty;
    logic [BEAT_CHANNEL_W-1:0] channel;
  } beat_t;

endpackage

// File: rtl/ast_packet_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after last, wrapping.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned GW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last,
  output logic          found,
  output logic [GW-1:0] idx
);

  logic [GW-1:0] cand;

  // Scan N candidates starting just after the previous winner.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = GW'((32'(last) + i) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/ast_packet_arbiter.sv
// Packet-locked round-robin merge of N_PORTS Avalon-ST sources, one cycle latency.
// Optional: AST_PACKET_ARBITER_PORT_TAG_EN replaces the output channel with the port index.
module ast_packet_arbiter
  import ast_pkt_arb_pkg::*;
#(
  parameter int unsigned N_PORTS   = 4,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned EMPTY_W   = $clog2(DATA_W/8),
  parameter int unsigned CHANNEL_W = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [N_PORTS*DATA_W-1:0]      ast_data_i,
  input  logic [N_PORTS-1:0]             ast_startofpacket_i,
  input  logic [N_PORTS-1:0]             ast_endofpacket_i,
  input  logic [N_PORTS-1:0]             ast_valid_i,
  input  logic [N_PORTS*EMPTY_W-1:0]     ast_empty_i,
  input  logic [N_PORTS*CHANNEL_W-1:0]   ast_channel_i,
  output logic [N_PORTS-1:0]             ast_ready_o,
  output logic [DATA_W-1:0]              ast_data_o,
  output logic                           ast_startofpacket_o,
  output logic                           ast_endofpacket_o,
  output logic                           ast_valid_o,
  output logic [EMPTY_W-1:0]             ast_empty_o,
  output logic [CHANNEL_W-1:0]           ast_channel_o,
  input  logic                           ast_ready_i,
  output logic [grant_w(N_PORTS)-1:0]    grant_o,
  output logic                           drop_o
);

  localparam int unsigned GW = grant_w(N_PORTS);

  arb_state_t           state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d, last_q, last_d, pick, sel;
  logic                 found, load_en, acc, drop_d;
  logic [N_PORTS-1:0]   sop_req, ready_c;
  logic                 sel_valid, sel_sop, sel_eop;
  logic [DATA_W-1:0]    sel_data;
  logic [EMPTY_W-1:0]   sel_empty;
  logic [CHANNEL_W-1:0] sel_chan;

  assign sop_req     = ast_valid_i & ast_startofpacket_i;
  assign load_en     = !ast_valid_o | ast_ready_i;
  assign ast_ready_o = ready_c;
  assign grant_o     = (state_q == ARB_LOCKED) ? grant_q : last_q;

  rr_pick #(.N(N_PORTS), .GW(GW)) u_pick (
    .req  (sop_req),
    .last (last_q),
    .found(found),
    .idx  (pick)
  );

  // Select the beat of the locked port, or of the arbitration winner when idle.
  always_comb begin
    sel       = (state_q == ARB_LOCKED) ? grant_q : pick;
    sel_valid = 1'b0;
    sel_sop   = 1'b0;
    sel_eop   = 1'b0;
    sel_data  = '0;
    sel_empty = '0;
    sel_chan  = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (GW'(k) == sel) begin
        sel_valid = ast_valid_i[k];
        sel_sop   = ast_startofpacket_i[k];
        sel_eop   = ast_endofpacket_i[k];
        sel_data  = ast_data_i[k*DATA_W +: DATA_W];
        sel_empty = ast_empty_i[k*EMPTY_W +: EMPTY_W];
        sel_chan  = ast_channel_i[k*CHANNEL_W +: CHANNEL_W];
      end
    end
  end

  // Next state, per-port ready, accept and stray-drop decisions.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    ready_c = '0;
    acc     = 1'b0;
    drop_d  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (found) begin
          for (int k = 0; k < N_PORTS; k++) begin
            if (GW'(k) == pick) ready_c[k] = load_en;
          end
          acc = load_en;
          if (acc) begin
            if (sel_eop) begin
              last_d = pick;
            end else begin
              state_d = ARB_LOCKED;
              grant_d = pick;
            end
          end
        end else begin
          // Non-SOP beats are flushed only when nobody is starting a packet.
          ready_c = ~ast_startofpacket_i;
          drop_d  = |(ast_valid_i & ~ast_startofpacket_i);
        end
      end
      ARB_LOCKED: begin
        for (int k = 0; k < N_PORTS; k++) begin
          if (GW'(k) == grant_q) ready_c[k] = load_en;
        end
        acc = load_en & sel_valid;
        if (acc && sel_eop) begin
          state_d = ARB_IDLE;
          last_d  = grant_q;
        end
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= GW'(N_PORTS - 1);
      drop_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      drop_o  <= drop_d;
    end
  end

  // Output register stage, held while downstream stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ast_valid_o         <= 1'b0;
      ast_data_o          <= '0;
      ast_startofpacket_o <= 1'b0;
      ast_endofpacket_o   <= 1'b0;
      ast_empty_o         <= '0;
      ast_channel_o       <= '0;
    end else if (load_en) begin
      ast_valid_o <= acc;
      if (acc) begin
        ast_data_o          <= sel_data;
        ast_startofpacket_o <= sel_sop;
        ast_endofpacket_o   <= sel_eop;
        ast_empty_o         <= sel_empty;
`ifdef AST_PACKET_ARBITER_PORT_TAG_EN
        ast_channel_o       <= CHANNEL_W'(sel);
`else
        ast_channel_o       <= sel_chan;
`endif
      end
    end
  end

endmodule
